// File: rtl/expmul_pkg.sv
// Shared op encodings, sequencer state enum and default widths for the exp/mul datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package expmul_pkg;

  localparam int DW_DEF = 32;
  localparam int EW_DEF = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_POW = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RES_ISSUE,
    ST_RES_WAIT,
    ST_SQR_ISSUE,
    ST_SQR_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/expmul_mul_port.sv
// Holding register and valid/ready issue logic for the shared multiplier operand port.
// Latency: a load becomes mul_in_valid on the next cycle; it drops the cycle after the handshake.
// Backpressure: mul_a/mul_b/mul_in_valid are held unchanged while mul_in_ready is low.
module expmul_mul_port #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_a,
  input  logic [DW-1:0] load_b,
  output logic          mul_in_valid,
  input  logic          mul_in_ready,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  output logic          accept
);

  logic          vld_q, vld_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;

  // Next request: a load opens a request, a handshake closes it; operands only change on load.
  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    b_d   = b_q;
    if (vld_q && mul_in_ready) begin
      vld_d = 1'b0;
    end
    if (load) begin
      vld_d = 1'b1;
      a_d   = load_a;
      b_d   = load_b;
    end
  end

  // Request register with async clear so reset drops any outstanding request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign mul_in_valid = vld_q;
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign accept       = vld_q && mul_in_ready;

endmodule

// File: rtl/expmul_op_sequencer.sv
// Sequences MUL (A*B) and POW (A^B, LSB-first square-and-multiply) over one shared multiplier.
// Latency: MUL cmd at T -> mul_in_valid T+1 -> product T+2 -> rsp_valid T+3; POW adds 2 cycles per product.
// Backpressure: one op at a time (cmd_ready only in IDLE); operands held until mul_in_ready; response held until rsp_ready.
// Optional: define EXPMUL_SKIP_TRIVIAL_EN to resolve trivial operands in IDLE with no multiplier traffic.
module expmul_op_sequencer
  import expmul_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int EW = EW_DEF
) (
  input  logic            S_AXI_ACLK,
  input  logic            S_AXI_ARESETN,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_op,
  input  logic [DW-1:0]   cmd_a,
  input  logic [DW-1:0]   cmd_b,
  output logic            mul_in_valid,
  input  logic            mul_in_ready,
  output logic [DW-1:0]   mul_a,
  output logic [DW-1:0]   mul_b,
  input  logic            mul_out_valid,
  input  logic [2*DW-1:0] mul_p,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_result,
  output logic            rsp_ovf,
  output logic            busy
);

  state_e        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] base_q, base_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          ovf_q, ovf_d;
  logic          op_q, op_d;

  logic          port_accept;
  logic          issue_load;
  logic [DW-1:0] issue_a;
  logic [EW-1:0] cmd_exp;
  logic [EW-1:0] exp_shr;
  logic [DW-1:0] p_lo;
  logic          p_hi_nz;

  assign cmd_exp = cmd_b[EW-1:0];
  assign exp_shr = exp_q >> 1;
  assign p_lo    = mul_p[DW-1:0];
  assign p_hi_nz = |mul_p[2*DW-1:DW];

  // Next-state and datapath update; products are only consumed in the two WAIT states.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    ovf_d   = ovf_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          ovf_d = 1'b0;
          if (cmd_op == OP_MUL) begin
            acc_d   = cmd_a;
            base_d  = cmd_b;
            exp_d   = '0;
            state_d = ST_RES_ISSUE;
          end else begin
            acc_d  = DW'(1);
            base_d = cmd_a;
            if (cmd_exp == '0) begin
              exp_d   = '0;
              state_d = ST_DONE;
            end else if (cmd_exp[0]) begin
              exp_d   = cmd_exp;
              state_d = ST_RES_ISSUE;
            end else begin
              // SQR_ISSUE always sees the exponent already shifted past the bit being squared for.
              exp_d   = cmd_exp >> 1;
              state_d = ST_SQR_ISSUE;
            end
          end
`ifdef EXPMUL_SKIP_TRIVIAL_EN
          if (cmd_op == OP_MUL) begin
            if (cmd_a == '0 || cmd_b == '0) begin
              acc_d   = '0;
              state_d = ST_DONE;
            end else if (cmd_a == DW'(1)) begin
              acc_d   = cmd_b;
              state_d = ST_DONE;
            end else if (cmd_b == DW'(1)) begin
              acc_d   = cmd_a;
              state_d = ST_DONE;
            end
          end else begin
            if (cmd_a == DW'(1)) begin
              acc_d   = DW'(1);
              state_d = ST_DONE;
            end else if (cmd_a == '0 && cmd_exp != '0) begin
              acc_d   = '0;
              state_d = ST_DONE;
            end
          end
`endif
        end
      end
      ST_RES_ISSUE: begin
        if (port_accept) state_d = ST_RES_WAIT;
      end
      ST_RES_WAIT: begin
        if (mul_out_valid) begin
          acc_d = p_lo;
          ovf_d = ovf_q | p_hi_nz;
          if (op_q == OP_MUL) begin
            state_d = ST_DONE;
          end else begin
            exp_d   = exp_shr;
            state_d = (exp_shr == '0) ? ST_DONE : ST_SQR_ISSUE;
          end
        end
      end
      ST_SQR_ISSUE: begin
        if (port_accept) state_d = ST_SQR_WAIT;
      end
      ST_SQR_WAIT: begin
        if (mul_out_valid) begin
          base_d = p_lo;
          ovf_d  = ovf_q | p_hi_nz;
          if (exp_q[0]) begin
            state_d = ST_RES_ISSUE;
          end else begin
            exp_d   = exp_shr;
            state_d = ST_SQR_ISSUE;
          end
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Load the operand port on entry to an ISSUE state, using the values that state will hold.
  always_comb begin
    issue_load = ((state_d == ST_RES_ISSUE) || (state_d == ST_SQR_ISSUE)) &&
                 !((state_q == ST_RES_ISSUE) || (state_q == ST_SQR_ISSUE));
    issue_a    = (state_d == ST_RES_ISSUE) ? acc_d : base_d;
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      ovf_q   <= 1'b0;
      op_q    <= OP_MUL;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      ovf_q   <= ovf_d;
      op_q    <= op_d;
    end
  end

  expmul_mul_port #(.DW(DW)) u_mul_port (
    .clk          (S_AXI_ACLK),
    .rst_n        (S_AXI_ARESETN),
    .load         (issue_load),
    .load_a       (issue_a),
    .load_b       (base_d),
    .mul_in_valid (mul_in_valid),
    .mul_in_ready (mul_in_ready),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .accept       (port_accept)
  );

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = rsp_valid ? acc_q : '0;
  assign rsp_ovf    = rsp_valid & ovf_q;

endmodule
